regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 73 +++++++
 tb/tb_regfile_wb_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter between the ALU and load unit, with a pending-write scoreboard.
// Write port is registered one cycle after acceptance; the loser is held off via req_ready (no buffering).
module regfile_wb_arbiter #(
  parameter int reg_size = 32,
  parameter int reg_num  = 16,
  localparam int RW      = $clog2(reg_num)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [RW-1:0]       req_rd0,
  input  logic [RW-1:0]       req_rd1,
  input  logic [reg_size-1:0] req_data0,
  input  logic [reg_size-1:0] req_data1,
  output logic                we,
  output logic [RW-1:0]       rd,
  output logic [reg_size-1:0] d_in,
  input  logic                iss_valid,
  input  logic [RW-1:0]       iss_rd,
  input  logic [RW-1:0]       rs,
  input  logic [RW-1:0]       rt,
  output logic                stall,
  output logic [reg_num-1:0]  busy
);

  logic                ptr;
  logic                acc;
  logic                sel;
  logic [RW-1:0]       sel_rd;
  logic [reg_size-1:0] sel_data;
  logic [reg_num-1:0]  busy_nxt;

  // ptr holds the last grantee; on a conflict the other requester wins
  assign req_ready[0] = req_valid[0] && (!req_valid[1] || ptr);
  assign req_ready[1] = req_valid[1] && (!req_valid[0] || !ptr);

  assign acc      = |req_ready;
  assign sel      = req_ready[1];
  assign sel_rd   = sel ? req_rd1 : req_rd0;
  assign sel_data = sel ? req_data1 : req_data0;

  // A new producer marked at the same edge as a retiring write keeps the register busy
  always_comb begin
    busy_nxt = busy;
    if (acc)
      busy_nxt[sel_rd] = 1'b0;
    if (iss_valid)
      busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr  <= 1'b1;
      we   <= 1'b0;
      rd   <= '0;
      d_in <= '0;
      busy <= '0;
    end else begin
      we   <= acc && (sel_rd != '0);
      busy <= busy_nxt;
      if (acc) begin
        ptr  <= sel;
        rd   <= sel_rd;
        d_in <= sel_data;
      end
    end
  end

  assign stall = ((rs != '0) && busy[rs]) || ((rt != '0) && busy[rt]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed vector bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req_rd0, req_rd1;
  logic [31:0] req_data0, req_data1;
  logic        we;
  logic [3:0]  rd;
  logic [31:0] d_in;
  logic        iss_valid;
  logic [3:0]  iss_rd, rs, rt;
  logic        stall;
  logic [15:0] busy;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rd0(req_rd0), .req_rd1(req_rd1),
    .req_data0(req_data0), .req_data1(req_data1),
    .we(we), .rd(rd), .d_in(d_in),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .rs(rs), .rt(rt),
    .stall(stall), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  v;
    logic [3:0]  rd0, rd1;
    logic [31:0] d0, d1;
    logic        iv;
    logic [3:0]  ird, rs, rt;
    logic [1:0]  rdy;
    logic        we;
    logic        chk_wd;
    logic [3:0]  rd;
    logic [31:0] d;
    logic [15:0] busy;
    logic        st;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(logic [1:0] v, logic [3:0] rd0, logic [3:0] rd1,
                              logic [31:0] d0, logic [31:0] d1, logic iv,
                              logic [3:0] ird, logic [3:0] rs_i, logic [3:0] rt_i,
                              logic [1:0] rdy, logic we_e, logic chk_wd,
                              logic [3:0] rd_e, logic [31:0] d_e,
                              logic [15:0] busy_e, logic st);
    vec_t r;
    r.v = v; r.rd0 = rd0; r.rd1 = rd1; r.d0 = d0; r.d1 = d1;
    r.iv = iv; r.ird = ird; r.rs = rs_i; r.rt = rt_i;
    r.rdy = rdy; r.we = we_e; r.chk_wd = chk_wd; r.rd = rd_e; r.d = d_e;
    r.busy = busy_e; r.st = st;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t t);
    req_valid = t.v;  req_rd0 = t.rd0; req_rd1 = t.rd1;
    req_data0 = t.d0; req_data1 = t.d1;
    iss_valid = t.iv; iss_rd = t.ird; rs = t.rs; rt = t.rt;
  endtask

  initial begin
    //            v     rd0   rd1   d0            d1            iv    ird   rs    rt    rdy   we    chk   rd    d             busy        st
    tbl[0]  = mk(2'b11, 4'd3, 4'd7, 32'h0000_00A0, 32'h0000_00B1, 1'b0, 4'd0, 4'd0, 4'd0, 2'b01, 1'b1, 1'b1, 4'd3, 32'h0000_00A0, 16'h0000, 1'b0);
    tbl[1]  = mk(2'b11, 4'd3, 4'd7, 32'h0000_00A0, 32'h0000_00B1, 1'b0, 4'd0, 4'd0, 4'd0, 2'b10, 1'b1, 1'b1, 4'd7, 32'h0000_00B1, 16'h0000, 1'b0);
    tbl[2]  = mk(2'b11, 4'd3, 4'd7, 32'h0000_00A0, 32'h0000_00B1, 1'b0, 4'd0, 4'd0, 4'd0, 2'b01, 1'b1, 1'b1, 4'd3, 32'h0000_00A0, 16'h0000, 1'b0);
    tbl[3]  = mk(2'b11, 4'd3, 4'd7, 32'h0000_00A0, 32'h0000_00B1, 1'b0, 4'd0, 4'd0, 4'd0, 2'b10, 1'b1, 1'b1, 4'd7, 32'h0000_00B1, 16'h0000, 1'b0);
    tbl[4]  = mk(2'b01, 4'd5, 4'd0, 32'hDEAD_BEEF, 32'h0,         1'b0, 4'd0, 4'd0, 4'd0, 2'b01, 1'b1, 1'b1, 4'd5, 32'hDEAD_BEEF, 16'h0000, 1'b0);
    tbl[5]  = mk(2'b00, 4'd0, 4'd0, 32'h0,         32'h0,         1'b0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b1, 4'd5, 32'hDEAD_BEEF, 16'h0000, 1'b0);
    tbl[6]  = mk(2'b00, 4'd0, 4'd0, 32'h0,         32'h0,         1'b1, 4'd9, 4'd9, 4'd0, 2'b00, 1'b0, 1'b1, 4'd5, 32'hDEAD_BEEF, 16'h0200, 1'b1);
    tbl[7]  = mk(2'b10, 4'd0, 4'd9, 32'h0,         32'h0000_0099, 1'b0, 4'd0, 4'd9, 4'd0, 2'b10, 1'b1, 1'b1, 4'd9, 32'h0000_0099, 16'h0000, 1'b0);
    tbl[8]  = mk(2'b01, 4'd4, 4'd0, 32'h0000_0044, 32'h0,         1'b1, 4'd4, 4'd4, 4'd0, 2'b01, 1'b1, 1'b1, 4'd4, 32'h0000_0044, 16'h0010, 1'b1);
    tbl[9]  = mk(2'b01, 4'd0, 4'd0, 32'h0000_1234, 32'h0,         1'b1, 4'd0, 4'd0, 4'd4, 2'b01, 1'b0, 1'b0, 4'd0, 32'h0,         16'h0010, 1'b1);
    tbl[10] = mk(2'b10, 4'd0, 4'd4, 32'h0,         32'h0000_0055, 1'b0, 4'd0, 4'd0, 4'd0, 2'b10, 1'b1, 1'b1, 4'd4, 32'h0000_0055, 16'h0000, 1'b0);
    tbl[11] = mk(2'b11, 4'd1, 4'd2, 32'h0000_0011, 32'h0000_0022, 1'b0, 4'd0, 4'd0, 4'd0, 2'b01, 1'b1, 1'b1, 4'd1, 32'h0000_0011, 16'h0000, 1'b0);
    tbl[12] = mk(2'b00, 4'd0, 4'd0, 32'h0,         32'h0,         1'b0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b1, 4'd1, 32'h0000_0011, 16'h0000, 1'b0);
    tbl[13] = mk(2'b00, 4'd0, 4'd0, 32'h0,         32'h0,         1'b1, 4'd15, 4'd0, 4'd15, 2'b00, 1'b0, 1'b1, 4'd1, 32'h0000_0011, 16'h8000, 1'b1);

    rst_n = 1'b0;
    req_valid = 2'b00; req_rd0 = '0; req_rd1 = '0; req_data0 = '0; req_data1 = '0;
    iss_valid = 1'b0; iss_rd = '0; rs = '0; rt = '0;

    #3;
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_din", d_in, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      apply(tbl[i]);
      #1;
      chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_we", i), 32'(we), 32'(tbl[i].we));
      if (tbl[i].chk_wd) begin
        chk($sformatf("v%0d_rd", i), 32'(rd), 32'(tbl[i].rd));
        chk($sformatf("v%0d_din", i), d_in, tbl[i].d);
      end
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'(tbl[i].st));
    end

    // Asynchronous reset in the middle of a write cycle.
    req_valid = 2'b01; req_rd0 = 4'd6; req_data0 = 32'h0000_0066;
    iss_valid = 1'b1; iss_rd = 4'd6; rs = 4'd6; rt = 4'd0;
    @(posedge clk);
    #2;
    chk("mid_we_before", 32'(we), 32'd1);
    chk("mid_busy_before", 32'(busy), 32'h0000_8040);
    chk("mid_stall_before", 32'(stall), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_we_after", 32'(we), 32'd0);
    chk("mid_busy_after", 32'(busy), 32'd0);
    chk("mid_stall_after", 32'(stall), 32'd0);
    chk("mid_rd_after", 32'(rd), 32'd0);
    chk("mid_din_after", d_in, 32'd0);

    // First conflict after reset goes to requester 0, granted on the first edge.
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 2'b11; req_rd0 = 4'd3; req_rd1 = 4'd7;
    req_data0 = 32'h0000_0A0A; req_data1 = 32'h0000_0B0B;
    iss_valid = 1'b0; iss_rd = '0; rs = '0; rt = '0;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'h1);
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_we", 32'(we), 32'd1);
    chk("post_rst_rd", 32'(rd), 32'd3);
    chk("post_rst_din", d_in, 32'h0000_0A0A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
